mem_bus_sequencer: RTL and testbench

- MEM-stage bus access controller for the pipelined MIPS CPU.
- Turns the decoder's MemRead/mem_w qualifiers for the instruction in EX/MEM into a request/ready transaction on the MIO bus (CPU_MIO / MIO_ready).
- Stalls the pipeline until the access completes, captures load data and aborts hung accesses with a timeout error.
- Sits between the EX/MEM pipeline register, the hazard/stall logic and the MIO bus.

---
 rtl/mio_pkg.sv | 7 +
 rtl/mio_timeout_cnt.sv | 19 +
 rtl/mem_bus_sequencer.sv | 89 ++++++++
 tb/tb_mem_bus_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// mio_pkg: shared FSM states, error-data default and access-kind encodings for the MIO bus sequencer
package mio_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [31:0] ERR_RDATA_DFLT = 32'h0000_0000;
  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;
endpackage

// File: rtl/mio_timeout_cnt.sv
// mio_timeout_cnt: saturating wait counter (clk, rst_n, clr, en -> tc when count == TIMEOUT_CYCLES-1)
module mio_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  end
  assign tc = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: MEM-stage MIO bus FSM (mem_rd_i/mem_w_i/addr_i/wdata_i in; stall_o, cpu_mio_o, bus_*_o, rdata*_o, err*_o out)
module mem_bus_sequencer
  import mio_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_i,
  input  logic        mem_w_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mio_ready_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        err_clr_i,
  output logic        stall_o,
  output logic        cpu_mio_o,
  output logic        bus_mem_w_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        bus_err_o,
  output logic        err_sticky_o,
  output logic [31:0] err_addr_o
);
  state_t state, nxt;
  logic kind, tc;
  logic req;
  assign req = mem_rd_i | mem_w_i;
  mio_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state != WAIT), .en(state == WAIT), .tc(tc)
  );
  always_comb begin
    nxt = state;
    stall_o = 1'b0;
    cpu_mio_o = 1'b0;
    bus_err_o = 1'b0;
    rdata_valid_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req;
        nxt = req ? REQ : IDLE;
      end
      REQ: begin
        stall_o = 1'b1;
        cpu_mio_o = 1'b1;
        nxt = mio_ready_i ? DONE : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        cpu_mio_o = 1'b1;
        bus_err_o = ~mio_ready_i & tc;
        nxt = (mio_ready_i | tc) ? DONE : WAIT;
      end
      DONE: begin
        rdata_valid_o = kind == KIND_RD;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign bus_mem_w_o = cpu_mio_o & (kind == KIND_WR);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      kind <= KIND_RD;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
      rdata_o <= '0;
      err_sticky_o <= 1'b0;
      err_addr_o <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        bus_addr_o <= addr_i;
        bus_wdata_o <= wdata_i;
        kind <= (mem_w_i & ~mem_rd_i) ? KIND_WR : KIND_RD;
      end
      if (cpu_mio_o && mio_ready_i && kind == KIND_RD) rdata_o <= bus_rdata_i;
      else if (bus_err_o && kind == KIND_RD) rdata_o <= ERR_RDATA;
      if (bus_err_o) begin
        err_sticky_o <= 1'b1;
        err_addr_o <= bus_addr_o;
      end else if (err_clr_i) err_sticky_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer: random and directed checks of mem_bus_sequencer against a latency-based access model
module tb_mem_bus_sequencer;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_rd_i = 0, mem_w_i = 0, mio_ready_i = 0, err_clr_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic stall_o, cpu_mio_o, bus_mem_w_o, rdata_valid_o, bus_err_o, err_sticky_o;
  logic [31:0] bus_addr_o, bus_wdata_o, rdata_o, err_addr_o;
  int passes = 0, total = 0;
  bit acc, fin, m_rd, m_sticky;
  int k;
  logic [31:0] m_a, m_d, m_rdata, m_eaddr;

  mem_bus_sequencer #(.TIMEOUT_CYCLES(T), .ERR_RDATA(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd_i(mem_rd_i), .mem_w_i(mem_w_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .mio_ready_i(mio_ready_i), .bus_rdata_i(bus_rdata_i), .err_clr_i(err_clr_i),
    .stall_o(stall_o), .cpu_mio_o(cpu_mio_o), .bus_mem_w_o(bus_mem_w_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .bus_err_o(bus_err_o),
    .err_sticky_o(err_sticky_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask

  task automatic model_reset();
    acc = 0; fin = 0; m_rd = 0; m_sticky = 0; k = 0;
    m_a = 0; m_d = 0; m_rdata = 0; m_eaddr = 0;
  endtask

  // One bus cycle: drive, check every output against the model, then advance the model.
  // Access cycles are numbered from the detection cycle: k=1 is the request cycle,
  // k=2..T+1 are the wait cycles, so an unanswered access gives up at k=T+1.
  task automatic cyc(input logic rd, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic [31:0] brd, input logic clr);
    bit req, to;
    @(negedge clk);
    mem_rd_i = rd; mem_w_i = w; addr_i = a; wdata_i = d;
    mio_ready_i = rdy; bus_rdata_i = brd; err_clr_i = clr;
    #1;
    req = rd | w;
    to = acc && !rdy && k == T + 1;
    chk("stall", {31'b0, stall_o}, {31'b0, acc ? 1'b1 : fin ? 1'b0 : req});
    chk("cpu_mio", {31'b0, cpu_mio_o}, {31'b0, acc});
    chk("bus_mem_w", {31'b0, bus_mem_w_o}, {31'b0, acc && !m_rd});
    if (acc) begin
      chk("bus_addr", bus_addr_o, m_a);
      chk("bus_wdata", bus_wdata_o, m_d);
    end
    chk("rdata_valid", {31'b0, rdata_valid_o}, {31'b0, fin && m_rd});
    chk("bus_err", {31'b0, bus_err_o}, {31'b0, to});
    chk("rdata", rdata_o, m_rdata);
    chk("err_sticky", {31'b0, err_sticky_o}, {31'b0, m_sticky});
    chk("err_addr", err_addr_o, m_eaddr);
    if (fin) fin = 0;
    else if (acc) begin
      if (rdy || k == T + 1) begin
        acc = 0; fin = 1;
        if (m_rd) m_rdata = rdy ? brd : 32'h0;
      end else k++;
    end else if (req) begin
      acc = 1; k = 1; m_rd = rd; m_a = a; m_d = d;
    end
    if (to) begin
      m_sticky = 1; m_eaddr = m_a;
    end else if (clr) m_sticky = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_mio", {31'b0, cpu_mio_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", {30'b0, err_sticky_o, bus_err_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    // zero-wait load
    cyc(1, 0, 32'h40, 0, 0, 0, 0);
    chk("zw_stall0", {31'b0, stall_o}, 32'h1);
    cyc(1, 0, 32'h40, 0, 1, 32'hCAFE_F00D, 0);
    chk("zw_mio", {31'b0, cpu_mio_o}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("zw_valid", {31'b0, rdata_valid_o}, 32'h1);
    chk("zw_rdata", rdata_o, 32'hCAFE_F00D);
    chk("zw_stall2", {31'b0, stall_o}, 32'h0);
    idle(1);
    // store with three wait cycles
    cyc(0, 1, 32'h80, 32'h1234_5678, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h80, 32'h1234_5678, 0, 0, 0);
    chk("st_memw", {31'b0, bus_mem_w_o}, 32'h1);
    chk("st_wdata", bus_wdata_o, 32'h1234_5678);
    cyc(0, 1, 32'h80, 32'h1234_5678, 1, 32'h5555_5555, 0);
    chk("st_stall", {31'b0, stall_o}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("st_valid", {31'b0, rdata_valid_o}, 32'h0);
    chk("st_rdata_held", rdata_o, 32'hCAFE_F00D);
    idle(1);
    // load timeout
    cyc(1, 0, 32'hFFFF_0000, 0, 0, 0, 0);
    cyc(1, 0, 32'hFFFF_0000, 0, 0, 0, 0);
    for (int i = 0; i < T - 1; i++) cyc(1, 0, 32'hFFFF_0000, 0, 0, 0, 0);
    chk("to_noerr_early", {31'b0, bus_err_o}, 32'h0);
    cyc(1, 0, 32'hFFFF_0000, 0, 0, 0, 1);
    chk("to_err_pulse", {31'b0, bus_err_o}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("to_sticky", {31'b0, err_sticky_o}, 32'h1);
    chk("to_eaddr", err_addr_o, 32'hFFFF_0000);
    chk("to_rdata", rdata_o, 32'h0);
    chk("to_release", {31'b0, stall_o}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("clr_sticky", {31'b0, err_sticky_o}, 32'h0);
    // ready on the last possible wait cycle
    cyc(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, 0, 32'h100, 0, 0, 0, 0);
    for (int i = 0; i < T - 1; i++) cyc(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, 0, 32'h100, 0, 1, 32'hA5A5_0001, 0);
    chk("race_noerr", {31'b0, bus_err_o}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("race_rdata", rdata_o, 32'hA5A5_0001);
    chk("race_sticky", {31'b0, err_sticky_o}, 32'h0);
    // back-to-back load then dual-qualified access
    cyc(1, 0, 32'h200, 0, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 1, 32'h0000_0BB1, 0);
    cyc(1, 1, 32'h204, 32'h77, 0, 0, 0);
    chk("b2b_done_nostall", {31'b0, stall_o}, 32'h0);
    cyc(1, 1, 32'h204, 32'h77, 0, 0, 0);
    chk("b2b_detect", {31'b0, stall_o}, 32'h1);
    cyc(1, 1, 32'h204, 32'h77, 1, 32'h0000_0BB2, 0);
    chk("dual_is_read", {31'b0, bus_mem_w_o}, 32'h0);
    chk("dual_addr", bus_addr_o, 32'h204);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dual_valid", {31'b0, rdata_valid_o}, 32'h1);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom,
          $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 15) == 0);
    // asynchronous reset while waiting
    cyc(1, 0, 32'h300, 0, 0, 0, 0);
    while (!acc) cyc(1, 0, 32'h300, 0, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0, 0);
    mem_rd_i = 0; mem_w_i = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_stall", {31'b0, stall_o}, 32'h0);
    chk("arst_mio", {31'b0, cpu_mio_o}, 32'h0);
    chk("arst_memw", {31'b0, bus_mem_w_o}, 32'h0);
    chk("arst_addr", bus_addr_o, 32'h0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_err", {29'b0, err_sticky_o, bus_err_o, rdata_valid_o}, 32'h0);
    chk("arst_eaddr", err_addr_o, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 0, 32'h400, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0F0F_0F0F, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_rdata", rdata_o, 32'h0F0F_0F0F);
    idle(2);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
